// File: rtl/ccip_avmm_pkg.sv
// ---------------------------------------------------------------------------
// ccip_avmm_pkg
// Shared widths and types for the CCI-P MMIO AVMM slice.
//   CCIP_AVMM_MMIO_ADDR_WIDTH / CCIP_AVMM_MMIO_DATA_WIDTH : MMIO AVMM bus widths
//   t_mmio_arb_id    : identifies one of the two MMIO masters (also the read tag)
//   t_mmio_arb_state : arbiter FSM state (ARB = free to choose, HOLD = locked)
// ---------------------------------------------------------------------------
package ccip_avmm_pkg;

  localparam int CCIP_AVMM_MMIO_ADDR_WIDTH = 18;
  localparam int CCIP_AVMM_MMIO_DATA_WIDTH = 64;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } t_mmio_arb_id;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } t_mmio_arb_state;

endpackage

// File: rtl/ccip_avmm_mmio_arb_tagfifo.sv
// ---------------------------------------------------------------------------
// ccip_avmm_mmio_arb_tagfifo
// Register-based in-order FIFO of read tags (which master issued each read).
// The head entry is visible combinationally so a response can be routed in the
// same cycle it arrives. Push and pop in the same cycle leave occupancy
// unchanged and are accepted even when full.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (flushes all tags)
//   push, push_id: enqueue a tag
//   pop          : dequeue head (ignored when empty)
//   head_id      : tag at the head
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module ccip_avmm_mmio_arb_tagfifo
  import ccip_avmm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  t_mmio_arb_id push_id,
  input  logic         pop,
  output t_mmio_arb_id head_id,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  t_mmio_arb_id   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head_id = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ccip_avmm_mmio_arb.sv
// ---------------------------------------------------------------------------
// ccip_avmm_mmio_arb
// Two-master round-robin arbiter in front of the shared MMIO AVMM slave.
// m0 = host MMIO path (CCI-P bridge), m1 = internal config master.
// Command path is combinational; read responses are routed back through an
// in-order tag FIFO with zero added latency.
//
// Handshake: a master holds m*_read/m*_write (and address/data) until it sees
// m*_waitrequest low in a cycle; that cycle is the accept. The slave side obeys
// the same rule, and once the slave stalls a command the grant is locked (HOLD)
// so s_* stays stable until the slave accepts it.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   m{0,1}_*                   : AVMM master-side ports (slave-facing to masters)
//   s_*                        : AVMM master port towards the shared slave
//   rsp_orphan                 : sticky, a response arrived with no read pending
//   dbg_state                  : current arbiter FSM state
// Optional build macro CCIP_AVMM_MMIO_ARB_STATS_EN adds saturating counters
//   stat_m0_cmds, stat_m1_cmds (accepted commands), stat_stall_cycles
//   (cycles in which any asserted command saw waitrequest).
// ---------------------------------------------------------------------------
module ccip_avmm_mmio_arb
  import ccip_avmm_pkg::*;
#(
  parameter int MAX_PENDING_RD = 16,
  localparam int RD_TAG_AW     = $clog2(MAX_PENDING_RD),
  localparam int AW            = CCIP_AVMM_MMIO_ADDR_WIDTH,
  localparam int DW            = CCIP_AVMM_MMIO_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  // master 0 (host MMIO)
  input  logic [AW-1:0]   m0_address,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_write,
  input  logic            m0_read,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,
  // master 1 (internal config)
  input  logic [AW-1:0]   m1_address,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_write,
  input  logic            m1_read,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  // shared slave
  output logic [AW-1:0]   s_address,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  output logic            s_write,
  output logic            s_read,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_readdatavalid,
  // status
  output logic            rsp_orphan,
  output t_mmio_arb_state dbg_state
`ifdef CCIP_AVMM_MMIO_ARB_STATS_EN
  ,
  output logic [31:0]     stat_m0_cmds,
  output logic [31:0]     stat_m1_cmds,
  output logic [31:0]     stat_stall_cycles
`endif
);

  t_mmio_arb_state state_q, state_d;
  t_mmio_arb_id    gnt_q, rr_last_q, grant;
  logic            grant_valid;
  logic            req0, req1;
  logic            g_write, g_read, cmd_issue, cmd_accept;
  logic            orphan_q;
  logic            tag_push, tag_pop, tag_full, tag_empty;
  t_mmio_arb_id    tag_head;

  // A read can only become a request while a tag slot is free.
  assign req0 = m0_write | (m0_read & ~tag_full);
  assign req1 = m1_write | (m1_read & ~tag_full);

  // ---------------- arbitration ----------------
  always_comb begin
    grant       = ARB_M0;
    grant_valid = 1'b0;
    if (!reset) begin
      if (state_q == HOLD) begin
        grant       = gnt_q;
        grant_valid = 1'b1;
      end else begin
        case ({req1, req0})
          2'b01: begin grant = ARB_M0; grant_valid = 1'b1; end
          2'b10: begin grant = ARB_M1; grant_valid = 1'b1; end
          2'b11: begin
            grant       = (rr_last_q == ARB_M0) ? ARB_M1 : ARB_M0;
            grant_valid = 1'b1;
          end
          default: begin grant = ARB_M0; grant_valid = 1'b0; end
        endcase
      end
    end
  end

  // Write wins over a simultaneous read from the same master (protocol error).
  assign g_write    = grant_valid & ((grant == ARB_M1) ? m1_write : m0_write);
  assign g_read     = grant_valid & ~g_write & ~tag_full &
                      ((grant == ARB_M1) ? m1_read : m0_read);
  assign cmd_issue  = g_write | g_read;
  assign cmd_accept = cmd_issue & ~s_waitrequest;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      gnt_q     <= ARB_M0;
      rr_last_q <= ARB_M1;
      orphan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ARB) && cmd_issue && s_waitrequest) gnt_q <= grant;
      if (cmd_accept) rr_last_q <= grant;
      if (s_readdatavalid && tag_empty) orphan_q <= 1'b1;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (cmd_issue && s_waitrequest) state_d = HOLD;
      HOLD:    if (!s_waitrequest) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    s_address        = (grant == ARB_M1) ? m1_address    : m0_address;
    s_writedata      = (grant == ARB_M1) ? m1_writedata  : m0_writedata;
    s_byteenable     = (grant == ARB_M1) ? m1_byteenable : m0_byteenable;
    s_write          = g_write;
    s_read           = g_read;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    if (cmd_issue) begin
      if (grant == ARB_M1) m1_waitrequest = s_waitrequest;
      else                 m0_waitrequest = s_waitrequest;
    end
    tag_push         = cmd_accept & g_read;
    tag_pop          = ~reset & s_readdatavalid & ~tag_empty;
    m0_readdatavalid = tag_pop & (tag_head == ARB_M0);
    m1_readdatavalid = tag_pop & (tag_head == ARB_M1);
  end

  // Broadcast data; only the master with readdatavalid takes it.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign rsp_orphan  = orphan_q;
  assign dbg_state   = state_q;

  ccip_avmm_mmio_arb_tagfifo #(
    .DEPTH (MAX_PENDING_RD),
    .AW    (RD_TAG_AW)
  ) u_tagfifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tag_push),
    .push_id (grant),
    .pop     (tag_pop),
    .head_id (tag_head),
    .full    (tag_full),
    .empty   (tag_empty)
  );

`ifdef CCIP_AVMM_MMIO_ARB_STATS_EN
  logic stall_now;
  assign stall_now = ((m0_read | m0_write) & m0_waitrequest) |
                     ((m1_read | m1_write) & m1_waitrequest);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_m0_cmds      <= '0;
      stat_m1_cmds      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (cmd_accept && (grant == ARB_M0) && (stat_m0_cmds != '1))
        stat_m0_cmds <= stat_m0_cmds + 32'd1;
      if (cmd_accept && (grant == ARB_M1) && (stat_m1_cmds != '1))
        stat_m1_cmds <= stat_m1_cmds + 32'd1;
      if (stall_now && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
